// File: rtl/subtractor_serial_nbit_pkg.sv
// Shared datapath definitions: FSM state encoding and default operand width,
// common to the serial subtractor and the combinational adder.
package subtractor_serial_nbit_pkg;

    localparam int unsigned DEFAULT_ADDER_WIDTH = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/subtractor_serial_nbit_fsub.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_xy;

    assign w_xy = x ^ y;
    assign d    = w_xy ^ bin;
    assign bout = (~x & y) | (~w_xy & bin);

endmodule

// File: rtl/subtractor_serial_nbit.sv
// Bit-serial N-bit subtractor: diff = a - b, LSB first, one bit per clock,
// with start/busy/done handshake and a single borrow flip-flop.
module subtractor_serial_nbit
    import subtractor_serial_nbit_pkg::*;
#(
    parameter int unsigned N     = DEFAULT_ADDER_WIDTH,
    parameter int unsigned CNT_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow
);

    state_t             r_state;
    logic [N-1:0]       r_sa;
    logic [N-1:0]       r_sb;
    logic [N-1:0]       r_work;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;
    logic [N-1:0]       r_diff;
    logic               r_borrow;
    logic               r_done;

    logic               w_d;
    logic               w_bout;

    full_subtractor_1bit u_fsub (
        .x    (r_sa[0]),
        .y    (r_sb[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_work   <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_work  <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_br   <= w_bout;
                    r_work <= {w_d, r_work[N-1:1]};
                    r_sa   <= {1'b0, r_sa[N-1:1]};
                    r_sb   <= {1'b0, r_sb[N-1:1]};
                    r_cnt  <= r_cnt + CNT_W'(1);
                    // Last bit: publish the assembled result directly, bypassing r_work.
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_diff   <= {w_d, r_work[N-1:1]};
                        r_borrow <= w_bout;
                        r_done   <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = (r_state == SHIFT);
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_subtractor_serial_nbit.sv
// Directed self-checking bench for subtractor_serial_nbit (N=10).
module tb_subtractor_serial_nbit;

    localparam int unsigned N = 10;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow;

    int n_checks = 0;
    int n_fail   = 0;

    subtractor_serial_nbit #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .borrow  (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"},   32'(busy),   32'd0);
        chk({tag, "_done"},   32'(done),   32'd0);
        chk({tag, "_diff"},   32'(diff),   32'd0);
        chk({tag, "_borrow"}, 32'(borrow), 32'd0);
    endtask

    // Accept one operation, then step N edges checking the handshake and result.
    task automatic run_op(input string tag, input logic [N-1:0] va, input logic [N-1:0] vb,
                          input logic [N-1:0] exp_d, input logic exp_b);
        a = va;
        b = vb;
        start = 1'b1;
        step();
        start = 1'b0;
        a = '1;
        b = '0;
        chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        for (int i = 1; i < N; i++) begin
            step();
            chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
            chk({tag, "_done_early"}, 32'(done), 32'd0);
        end
        step();
        chk({tag, "_done"},   32'(done),   32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_diff"},   32'(diff),   32'(exp_d));
        chk({tag, "_borrow"}, 32'(borrow), 32'(exp_b));
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_diff_hold"},  32'(diff), 32'(exp_d));
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;

        // Reset then idle
        repeat (3) step();
        chk_idle_zero("reset");
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_idle_zero("idle");
        end

        // Basic and boundary vectors
        run_op("b100_47",   10'd100,  10'd47,   10'd53,   1'b1 ^ 1'b1);
        run_op("b33_47",    10'd33,   10'd47,   10'd1010, 1'b1);
        run_op("z0_0",      10'd0,    10'd0,    10'd0,    1'b0);
        run_op("z0_1023",   10'd0,    10'd1023, 10'd1,    1'b1);
        run_op("m1023_1023",10'd1023, 10'd1023, 10'd0,    1'b0);
        run_op("m1023_0",   10'd1023, 10'd0,    10'd1023, 1'b0);

        // Start while busy is ignored
        a = 10'd100;
        b = 10'd47;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        a = 10'd5;
        b = 10'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ignore_busy", 32'(busy), 32'd1);
        repeat (N - 6) begin
            step();
            chk("ignore_no_early_done", 32'(done), 32'd0);
        end
        step();
        chk("ignore_done", 32'(done), 32'd1);
        chk("ignore_diff", 32'(diff), 32'd53);
        chk("ignore_borrow", 32'(borrow), 32'd0);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("ignore_no_second_done", 32'(done), 32'd0);
        end
        chk("ignore_idle", 32'(busy), 32'd0);

        // Back-to-back with start held high
        a = 10'd1;
        b = 10'd99;
        start = 1'b1;
        step();
        for (int i = 1; i < N; i++) begin
            step();
            chk("b2b_first_wait", 32'(done), 32'd0);
        end
        step();
        chk("b2b_first_done",   32'(done),   32'd1);
        chk("b2b_first_diff",   32'(diff),   32'd926);
        chk("b2b_first_borrow", 32'(borrow), 32'd1);
        a = 10'd33;
        b = 10'd47;
        step();
        chk("b2b_reaccept_busy", 32'(busy), 32'd1);
        chk("b2b_reaccept_done", 32'(done), 32'd0);
        start = 1'b0;
        for (int i = 1; i < N; i++) begin
            step();
            chk("b2b_second_wait", 32'(done), 32'd0);
            chk("b2b_hold_diff", 32'(diff), 32'd926);
        end
        step();
        chk("b2b_second_done",   32'(done),   32'd1);
        chk("b2b_second_diff",   32'(diff),   32'd1010);
        chk("b2b_second_borrow", 32'(borrow), 32'd1);

        // Reset mid-operation
        step();
        a = 10'd100;
        b = 10'd47;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        chk_idle_zero("midreset");
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("midreset_no_done", 32'(done), 32'd0);
        end
        run_op("after_reset", 10'd2, 10'd1, 10'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
